// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix memory sequencer: geometry, opcodes,
// FSM state encoding and small slice/decode helpers.
package matrix_pkg;

  localparam int unsigned ELEM_W = 16;
  localparam int unsigned DIM    = 4;
  localparam int unsigned MAT_W  = ELEM_W * DIM * DIM;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned MADR_W = 4;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_TRN = 2'b10;
  localparam logic [OP_W-1:0] OP_SCL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_A_REQ  = 3'd1,
    ST_RD_A_WAIT = 3'd2,
    ST_RD_B_REQ  = 3'd3,
    ST_RD_B_WAIT = 3'd4,
    ST_EXEC      = 3'd5,
    ST_WR        = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  // LSB position of element (r,c) inside a packed matrix word.
  function automatic int unsigned elem_lsb(input int unsigned r, input int unsigned c);
    return ELEM_W * (DIM * r + c);
  endfunction

  // Add and sub are the only two-operand instructions.
  function automatic logic needs_operand_b(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/matrix_mem_ctrl_if.sv
// Instruction handshake plus memory control strobes of the matrix sequencer.
//   start/op/srcA/srcB/dest/scalar : instruction from the issuer
//   busy/done                      : sequencer status
//   memAddr/memNEnable/memReadWrite: memory control (data travels on dataBus)
// master = sequencer side, slave = issuer/memory side.
interface matrix_mem_ctrl_if;
  import matrix_pkg::*;

  logic                start;
  logic [OP_W-1:0]     op;
  logic [ADDR_W-1:0]   srcA;
  logic [ADDR_W-1:0]   srcB;
  logic [ADDR_W-1:0]   dest;
  logic [ELEM_W-1:0]   scalar;
  logic                busy;
  logic                done;
  logic [MADR_W-1:0]   memAddr;
  logic                memNEnable;
  logic                memReadWrite;

  modport master (
    input  start, op, srcA, srcB, dest, scalar,
    output busy, done, memAddr, memNEnable, memReadWrite
  );

  modport slave (
    output start, op, srcA, srcB, dest, scalar,
    input  busy, done, memAddr, memNEnable, memReadWrite
  );

endinterface

// File: rtl/matrix_alu.sv
// Combinational 4x4 matrix datapath: element-wise add/sub/scale and transpose.
//   i_a, i_b    : operand matrices
//   i_scalar    : scale factor (op 11)
//   i_op        : opcode
//   o_result_c  : result matrix (combinational)
module matrix_alu
  import matrix_pkg::*;
(
  input  logic [MAT_W-1:0]  i_a,
  input  logic [MAT_W-1:0]  i_b,
  input  logic [ELEM_W-1:0] i_scalar,
  input  logic [OP_W-1:0]   i_op,
  output logic [MAT_W-1:0]  o_result_c
);

  // All element math wraps modulo 2^16; a 16x16 product truncated to 16 bits
  // equals the low half of the full product.
  always_comb begin
    o_result_c = '0;
    for (int unsigned r = 0; r < DIM; r++) begin
      for (int unsigned c = 0; c < DIM; c++) begin
        case (i_op)
          OP_ADD: o_result_c[elem_lsb(r, c) +: ELEM_W] =
                    i_a[elem_lsb(r, c) +: ELEM_W] + i_b[elem_lsb(r, c) +: ELEM_W];
          OP_SUB: o_result_c[elem_lsb(r, c) +: ELEM_W] =
                    i_a[elem_lsb(r, c) +: ELEM_W] - i_b[elem_lsb(r, c) +: ELEM_W];
          OP_TRN: o_result_c[elem_lsb(r, c) +: ELEM_W] = i_a[elem_lsb(c, r) +: ELEM_W];
          OP_SCL: o_result_c[elem_lsb(r, c) +: ELEM_W] =
                    i_a[elem_lsb(r, c) +: ELEM_W] * i_scalar;
          default: o_result_c[elem_lsb(r, c) +: ELEM_W] = '0;
        endcase
      end
    end
  end

endmodule

// File: rtl/matrix_mem_ctrl.sv
// Matrix instruction sequencer: reads one or two operand matrices from the
// matrix memory, computes the result and writes it back, then pulses done.
//   clk     : clock (memory reads on posedge, writes on negedge)
//   Reset   : synchronous active-high reset
//   bus     : instruction handshake + memory control (master modport)
//   dataBus : shared tristate data bus, driven only in WR
module matrix_mem_ctrl
  import matrix_pkg::*;
(
  input  logic                clk,
  input  logic                Reset,
  matrix_mem_ctrl_if.master   bus,
  inout  wire  [MAT_W-1:0]    dataBus
);

  state_e              r_state;
  logic [OP_W-1:0]     r_op;
  logic [ADDR_W-1:0]   r_src_b;
  logic [ADDR_W-1:0]   r_dest;
  logic [ELEM_W-1:0]   r_scalar;
  logic [MAT_W-1:0]    r_a;
  logic [MAT_W-1:0]    r_b;
  logic [MAT_W-1:0]    r_result;
  logic                r_busy;
  logic                r_done;
  logic                r_mem_n_en;
  logic                r_mem_rw;
  logic [MADR_W-1:0]   r_mem_addr;
  logic                r_drive;
  logic [MAT_W-1:0]    w_alu_result;

  matrix_alu u_alu (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_scalar   (r_scalar),
    .i_op       (r_op),
    .o_result_c (w_alu_result)
  );

  // Sequencer; every control output is loaded together with the state it
  // belongs to, so outputs depend on the state register only.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_ADD;
      r_src_b    <= '0;
      r_dest     <= '0;
      r_scalar   <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_n_en <= 1'b1;
      r_mem_rw   <= 1'b1;
      r_mem_addr <= '0;
      r_drive    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op       <= bus.op;
            r_src_b    <= bus.srcB;
            r_dest     <= bus.dest;
            r_scalar   <= bus.scalar;
            r_busy     <= 1'b1;
            r_mem_n_en <= 1'b0;
            r_mem_rw   <= 1'b1;
            r_mem_addr <= {1'b0, bus.srcA};
            r_state    <= ST_RD_A_REQ;
          end
        end
        ST_RD_A_REQ: r_state <= ST_RD_A_WAIT;
        ST_RD_A_WAIT: begin
          r_a <= dataBus;
          if (needs_operand_b(r_op)) begin
            r_mem_addr <= {1'b0, r_src_b};
            r_state    <= ST_RD_B_REQ;
          end else begin
            r_mem_n_en <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_RD_B_REQ: r_state <= ST_RD_B_WAIT;
        ST_RD_B_WAIT: begin
          r_b        <= dataBus;
          r_mem_n_en <= 1'b1;
          r_state    <= ST_EXEC;
        end
        // Turnaround cycle: memory has released the bus before we drive it.
        ST_EXEC: begin
          r_result   <= w_alu_result;
          r_mem_n_en <= 1'b0;
          r_mem_rw   <= 1'b0;
          r_mem_addr <= {1'b0, r_dest};
          r_drive    <= 1'b1;
          r_state    <= ST_WR;
        end
        ST_WR: begin
          r_mem_n_en <= 1'b1;
          r_mem_rw   <= 1'b1;
          r_mem_addr <= '0;
          r_drive    <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dataBus          = r_drive ? r_result : {MAT_W{1'bz}};
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.memAddr      = r_mem_addr;
  assign bus.memNEnable   = r_mem_n_en;
  assign bus.memReadWrite = r_mem_rw;

endmodule

// File: tb/tb_matrix_mem_ctrl.sv
// Directed self-checking bench for matrix_mem_ctrl with an 8 x 256-bit
// memory model (registered read on posedge, write on negedge).
module tb_matrix_mem_ctrl;
  import matrix_pkg::*;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  wire  [MAT_W-1:0] dataBus;
  int checks = 0;
  int errors = 0;

  matrix_mem_ctrl_if ifc ();

  matrix_mem_ctrl dut (
    .clk     (clk),
    .Reset   (Reset),
    .bus     (ifc),
    .dataBus (dataBus)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [MAT_W-1:0]  mem [0:7];
  logic [MAT_W-1:0]  mem_rd = '0;
  logic              mem_rd_vld = 1'b0;
  logic              pre_we = 1'b0;
  logic [2:0]        pre_addr = '0;
  logic [MAT_W-1:0]  pre_data = '0;

  always @(posedge clk) begin
    if (!ifc.memNEnable && ifc.memReadWrite) begin
      mem_rd     <= mem[ifc.memAddr[2:0]];
      mem_rd_vld <= 1'b1;
    end else begin
      mem_rd_vld <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!ifc.memNEnable && !ifc.memReadWrite) mem[ifc.memAddr[2:0]] <= dataBus;
  end

  assign dataBus = (mem_rd_vld && !ifc.memNEnable && ifc.memReadWrite) ? mem_rd : {MAT_W{1'bz}};

  task automatic preload(input logic [2:0] a, input logic [MAT_W-1:0] d);
    @(posedge clk); #1;
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    ifc.start = 1'b0; ifc.op = OP_ADD; ifc.srcA = '0; ifc.srcB = '0; ifc.dest = '0; ifc.scalar = '0;
    repeat (3) @(negedge clk);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", ifc.busy); end
    checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", ifc.done); end
    checks++; if (ifc.memNEnable !== 1'b1) begin errors++; $display("FAIL reset memNEnable: got %b want 1", ifc.memNEnable); end
    checks++; if (ifc.memReadWrite !== 1'b1) begin errors++; $display("FAIL reset memReadWrite: got %b want 1", ifc.memReadWrite); end
    checks++; if (ifc.memAddr !== 4'h0) begin errors++; $display("FAIL reset memAddr: got %h want 0", ifc.memAddr); end
    checks++;
    if (dataBus !== {MAT_W{1'bz}} && dataBus !== {MAT_W{1'b0}}) begin
      errors++; $display("FAIL reset dataBus released: got %h", dataBus);
    end
    Reset = 1'b0;
  endtask

  // One full instruction with per-cycle control/bus expectations.
  // poke re-asserts start with different fields mid-operation.
  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] a,
                        input logic [2:0] b, input logic [2:0] d, input logic [15:0] scal,
                        input logic [MAT_W-1:0] exp, input bit poke);
    int lat, wr_k;
    bit two_op;
    logic exp_en, exp_rw;
    logic [3:0] exp_addr;
    two_op = (op == 2'b00) || (op == 2'b01);
    lat  = two_op ? 7 : 5;
    wr_k = lat - 1;
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = op; ifc.srcA = a; ifc.srcB = b; ifc.dest = d; ifc.scalar = scal;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k == 1) ifc.start = 1'b0;
      if (poke && k == 2) begin
        ifc.start = 1'b1; ifc.op = OP_ADD; ifc.srcA = a + 3'd1; ifc.srcB = b + 3'd1;
        ifc.dest = d + 3'd1; ifc.scalar = scal + 16'd1;
      end
      if (poke && k == 3) ifc.start = 1'b0;
      exp_en = 1'b0; exp_rw = 1'b1; exp_addr = 4'h0;
      if (k <= 2) begin exp_en = 1'b1; exp_addr = {1'b0, a}; end
      else if (two_op && k <= 4) begin exp_en = 1'b1; exp_addr = {1'b0, b}; end
      else if (k == wr_k) begin exp_en = 1'b1; exp_rw = 1'b0; exp_addr = {1'b0, d}; end
      checks++;
      if (ifc.busy !== (k <= lat)) begin errors++; $display("FAIL %s busy cycle %0d: got %b want %b", name, k, ifc.busy, (k <= lat)); end
      checks++;
      if (ifc.done !== (k == lat)) begin errors++; $display("FAIL %s done cycle %0d: got %b want %b", name, k, ifc.done, (k == lat)); end
      checks++;
      if (ifc.memNEnable !== !exp_en) begin errors++; $display("FAIL %s memNEnable cycle %0d: got %b want %b", name, k, ifc.memNEnable, !exp_en); end
      checks++;
      if (ifc.memReadWrite !== exp_rw) begin errors++; $display("FAIL %s memReadWrite cycle %0d: got %b want %b", name, k, ifc.memReadWrite, exp_rw); end
      if (exp_en) begin
        checks++;
        if (ifc.memAddr !== exp_addr) begin errors++; $display("FAIL %s memAddr cycle %0d: got %h want %h", name, k, ifc.memAddr, exp_addr); end
      end
      if (k == wr_k) begin
        checks++;
        if (dataBus !== exp) begin errors++; $display("FAIL %s write data: got %h want %h", name, dataBus, exp); end
      end else if (!exp_en) begin
        checks++;
        if (dataBus !== {MAT_W{1'bz}} && dataBus !== {MAT_W{1'b0}}) begin
          errors++; $display("FAIL %s bus not released cycle %0d: got %h", name, k, dataBus);
        end
      end
    end
    checks++;
    if (mem[d] !== exp) begin errors++; $display("FAIL %s mem[%0d]: got %h want %h", name, d, mem[d], exp); end
  endtask

  // start held through DONE is taken only at the first IDLE edge.
  task automatic test_back_to_back();
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_ADD; ifc.srcA = 3'd1; ifc.srcB = 3'd2; ifc.dest = 3'd3; ifc.scalar = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 7) begin
        checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL b2b first done: got %b want 1", ifc.done); end
      end
      if (k == 8) begin
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL b2b accepted in DONE: busy %b want 0", ifc.busy); end
      end
      if (k == 9) begin
        checks++; if (ifc.busy !== 1'b1) begin errors++; $display("FAIL b2b second accept: busy %b want 1", ifc.busy); end
        checks++; if (ifc.memAddr !== 4'h1) begin errors++; $display("FAIL b2b second addr: got %h want 1", ifc.memAddr); end
        ifc.start = 1'b0;
      end
      if (k == 15) begin
        checks++; if (ifc.done !== 1'b1) begin errors++; $display("FAIL b2b second done: got %b want 1", ifc.done); end
      end
      if (k == 16) begin
        checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL b2b end busy: got %b want 0", ifc.busy); end
      end
    end
    checks++;
    if (mem[3] !== {16{16'h0008}}) begin errors++; $display("FAIL b2b mem[3]: got %h", mem[3]); end
  endtask

  // Reset (together with start) at cycle abort_k of an add.
  task automatic test_reset_abort(input string name, input logic [2:0] d, input int abort_k,
                                  input logic [MAT_W-1:0] exp_mem);
    @(negedge clk);
    ifc.start = 1'b1; ifc.op = OP_ADD; ifc.srcA = 3'd1; ifc.srcB = 3'd2; ifc.dest = d; ifc.scalar = '0;
    for (int k = 1; k <= abort_k; k++) begin
      @(negedge clk);
      if (k == 1) ifc.start = 1'b0;
      checks++;
      if (ifc.busy !== 1'b1) begin errors++; $display("FAIL %s busy cycle %0d: got %b want 1", name, k, ifc.busy); end
    end
    Reset = 1'b1; ifc.start = 1'b1;
    @(negedge clk);
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL %s busy after reset: got %b", name, ifc.busy); end
    checks++; if (ifc.done !== 1'b0) begin errors++; $display("FAIL %s done after reset: got %b", name, ifc.done); end
    checks++; if (ifc.memNEnable !== 1'b1) begin errors++; $display("FAIL %s memNEnable after reset: got %b", name, ifc.memNEnable); end
    checks++; if (ifc.memReadWrite !== 1'b1) begin errors++; $display("FAIL %s memReadWrite after reset: got %b", name, ifc.memReadWrite); end
    checks++; if (ifc.memAddr !== 4'h0) begin errors++; $display("FAIL %s memAddr after reset: got %h", name, ifc.memAddr); end
    checks++;
    if (dataBus !== {MAT_W{1'bz}} && dataBus !== {MAT_W{1'b0}}) begin
      errors++; $display("FAIL %s bus after reset: got %h", name, dataBus);
    end
    Reset = 1'b0; ifc.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
        errors++; $display("FAIL %s activity after abort cycle %0d: busy %b done %b want 0 0", name, k, ifc.busy, ifc.done);
      end
    end
    checks++;
    if (mem[d] !== exp_mem) begin errors++; $display("FAIL %s mem[%0d]: got %h want %h", name, d, mem[d], exp_mem); end
  endtask

  initial begin
    logic [MAT_W-1:0] trn_in, trn_exp;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        trn_in[16*(4*r+c) +: 16]  = 16'(4*r + c);
        trn_exp[16*(4*r+c) +: 16] = 16'(4*c + r);
      end

    test_reset();
    preload(3'd1, {16{16'h0003}});
    preload(3'd2, {16{16'h0005}});
    preload(3'd0, {16{16'h0000}});
    preload(3'd4, {16{16'h0001}});
    preload(3'd6, trn_in);
    preload(3'd7, {16{16'h8001}});

    run_op("add",       OP_ADD, 3'd1, 3'd2, 3'd3, 16'h0000, {16{16'h0008}}, 1'b0);
    run_op("sub_wrap",  OP_SUB, 3'd0, 3'd4, 3'd5, 16'h0000, {16{16'hFFFF}}, 1'b0);
    run_op("transpose", OP_TRN, 3'd6, 3'd2, 3'd6, 16'h0000, trn_exp,        1'b0);
    run_op("scale",     OP_SCL, 3'd7, 3'd3, 3'd0, 16'h0002, {16{16'h0002}}, 1'b0);
    test_back_to_back();

    preload(3'd3, {16{16'h1111}});
    test_reset_abort("abort_rd_b", 3'd3, 4, {16{16'h1111}});
    test_reset_abort("abort_wr",   3'd5, 6, {16{16'h0008}});
    run_op("start_ignored", OP_SCL, 3'd7, 3'd1, 3'd4, 16'h0002, {16{16'h0002}}, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_mem_ctrl.md
# matrix_mem_ctrl

Sequencer that sits directly upstream of the 8-entry × 256-bit matrix memory and is the only master on its shared tristate data bus. It accepts one matrix instruction, reads one or two 4×4 16-bit operand matrices over the bus, computes the result, and writes it back to a destination address. It then pulses `done`.

## Interface
Parameters
- ELEM_W, 16, element width in bits
- DIM, 4, matrix dimension (DIM×DIM elements)
- MAT_W, 256, bus/matrix width = ELEM_W·DIM·DIM

Ports
- clk  in  1  clock; memory reads on posedge, writes on negedge
- Reset  in  1  synchronous, active-high reset
- start  in  1  instruction strobe, sampled only in IDLE
- op  in  2  00 add A+B, 01 sub A−B, 10 transpose A, 11 scale A by `scalar`
- srcA  in  3  address of operand A
- srcB  in  3  address of operand B (ignored for op 10/11)
- dest  in  3  result address
- scalar  in  16  scale factor for op 11
- busy  out  1  high from the cycle after `start` is accepted through the DONE cycle
- done  out  1  one-cycle pulse in DONE state
- memAddr  out  4  memory address = {1'b0, addr3}
- memNEnable  out  1  active-low memory enable
- memReadWrite  out  1  1 = read, 0 = write
- dataBus  inout  MAT_W  shared bus; driven only in WR, otherwise Z

## Operation
- Element (r,c) occupies bits [16·(4r+c)+15 : 16·(4r+c)].
- Arithmetic is modulo 2^16, and overflow wraps.
- Scale uses the low 16 bits of elem·scalar.
- Transpose: out(r,c) = A(c,r).
- States: IDLE → RD_A_REQ → RD_A_WAIT → (op 00/01: RD_B_REQ → RD_B_WAIT) → EXEC → WR → DONE → IDLE.
- IDLE: `start`=1 latches op, srcA, srcB, dest, scalar and moves to RD_A_REQ. `start` in any other state is ignored.
- RD_x_REQ and RD_x_WAIT: memNEnable=0, memReadWrite=1, memAddr=src. At the end of RD_x_WAIT, dataBus is captured into regA or regB.
- EXEC: memNEnable=1, which releases the bus (turnaround cycle). The result register is loaded from the ALU.
- WR: memNEnable=0, memReadWrite=0, memAddr=dest, dataBus=result. The memory commits at the mid-cycle negedge.
- DONE: memNEnable=1 and done=1. Next state is IDLE.
- Control outputs decode from the state register only. They do not depend on inputs combinationally.

## Timing
- Reset values: state IDLE, busy 0, done 0, memNEnable 1, memReadWrite 1, memAddr 0, dataBus Z, regA/regB/result 0.
- Latency from the posedge that samples `start`:
  - ops 00/01: done is high in the 7th following cycle.
  - ops 10/11: done is high in the 5th following cycle.
- Back-to-back: `start` held high in the DONE cycle is not accepted. It is accepted at the first IDLE edge, so the minimum issue interval is 8 or 6 cycles.
- Bus is never driven by this block while memReadWrite=1. At least one cycle with memNEnable=1 separates a memory read from a controller drive.
- srcA = srcB = dest is legal. Operands are captured before the write.
- Reset mid-operation: at the next posedge the block aborts to IDLE and outputs take their reset values. No later write occurs.
- Reset asserted during WR: the negedge write of that cycle still completes, because reset is synchronous.
- Reset and start on the same edge: Reset wins, and the instruction is dropped.

## Structure
- Shared package `matrix_pkg`:
  - opcode constants OP_ADD/OP_SUB/OP_TRN/OP_SCL
  - state encoding
  - ELEM_W, DIM, MAT_W
- Sub-module `matrix_alu`: combinational (a, b, scalar, op) → result, covering the element-wise add/sub/scale and transpose slice mapping.
- The FSM, operand registers and bus driver stay in `matrix_mem_ctrl`.

## Test plan
- Add: mem[1] = all elements 0x0003, mem[2] = all 0x0005; op 00, A=1, B=2, dest=3. Expect mem[3] = all 0x0008, done 7 cycles after start, busy high throughout.
- Sub wrap: mem[0] = all 0x0000, mem[4] = all 0x0001; op 00→01, A=0, B=4, dest=5. Expect mem[5] = all 0xFFFF.
- Transpose: mem[6] element (r,c) = 4r+c; op 10, A=6, dest=6. Expect mem[6] element (r,c) = 4c+r, done after 5 cycles, srcB never on memAddr.
- Scale overflow: mem[7] = all 0x8001, scalar = 0x0002; op 11. Expect result all 0x0002.
- Bus discipline: assert there are no cycles with dataBus driven by the controller while memReadWrite=1, and that dataBus is not Z-free except during WR or a memory read.
- Reset abort: assert Reset during RD_B_WAIT of an add to dest=3 holding 0x1111. Expect mem[3] unchanged, done never pulses, and all outputs at reset values the next cycle. Then start during busy and confirm it is ignored.
